controle_pc: RTL

Instruction-flow sequencer for the single-cycle-datapath MIPS core. It drives the program counter's `jump`, `halt` and `reseta` inputs, plus the instruction-register load and the architectural write enable. The PC therefore advances exactly once per instruction, after a fixed instruction-memory latency. It also handles HLT, the user-confirmed IN instruction and a button-driven single-step mode. It sits between the decoder and the PC/instruction memory.

---
 rtl/controle_pc_if.sv | 30 +++
 rtl/controle_pc.sv | 129 ++++++++++++
 2 files changed

// File: rtl/controle_pc_if.sv
// controle_pc_if: bus between the instruction-flow sequencer and the
// decoder / program counter / instruction register of the MIPS core.
//   Decoder -> sequencer : inst_hlt, inst_in, desvio_req, desvio_alvo
//   Sequencer -> PC/IR   : pc_reseta, pc_halt, pc_jump, pc_endereco,
//                          ir_carrega, escreve_habilita
// modport master is the sequencer side, modport slave the datapath side.
interface controle_pc_if #(
    parameter int LARG_END = 32
);
    logic                inst_hlt;
    logic                inst_in;
    logic                desvio_req;
    logic [LARG_END-1:0] desvio_alvo;
    logic                pc_reseta;
    logic                pc_halt;
    logic                pc_jump;
    logic [LARG_END-1:0] pc_endereco;
    logic                ir_carrega;
    logic                escreve_habilita;

    modport master (
        input  inst_hlt, inst_in, desvio_req, desvio_alvo,
        output pc_reseta, pc_halt, pc_jump, pc_endereco, ir_carrega, escreve_habilita
    );

    modport slave (
        output inst_hlt, inst_in, desvio_req, desvio_alvo,
        input  pc_reseta, pc_halt, pc_jump, pc_endereco, ir_carrega, escreve_habilita
    );
endinterface

// File: rtl/controle_pc.sv
// controle_pc: instruction-flow sequencer. Advances the PC exactly once per
// instruction after LAT_MEM cycles of instruction-memory latency, handles
// HLT (sticky stop), IN (waits for a button press) and single-step mode.
// Ports:
//   clock          system clock, rising edge
//   reseta         asynchronous active-low reset
//   passo_a_passo  single-step mode enable (level)
//   botao          raw asynchronous user button, active high
//   parado         core halted
//   estado         current state code for debug display
//   bus            controle_pc_if.master: decoder inputs, PC/IR controls
module controle_pc #(
    parameter int LAT_MEM  = 2,
    parameter int LARG_END = 32
) (
    input  logic              clock,
    input  logic              reseta,
    input  logic              passo_a_passo,
    input  logic              botao,
    output logic              parado,
    output logic [2:0]        estado,
    controle_pc_if.master     bus
);

    typedef enum logic [2:0] {
        INICIO       = 3'd0,
        BUSCA        = 3'd1,
        ESPERA_MEM   = 3'd2,
        EXECUTA      = 3'd3,
        ESPERA_IO    = 3'd4,
        ESPERA_PASSO = 3'd5,
        PARADO       = 3'd6
    } estado_t;

    estado_t             est;
    estado_t             prox;
    logic [3:0]          cont;
    logic                s1, s2, s3;
    logic                pulso;
    logic                avanca;
    logic [LARG_END-1:0] alvo_sel;

    // Button: two-flop synchronizer plus delay flop; rising-edge detect
    // gives one pulse per press regardless of hold length.
    always_ff @(posedge clock or negedge reseta) begin
        if (!reseta) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= botao;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulso = s2 & ~s3;

    always_ff @(posedge clock or negedge reseta) begin
        if (!reseta) begin
            est <= INICIO;
        end else begin
            est <= prox;
        end
    end

    // Latency counter: loaded in BUSCA, counts down to zero in ESPERA_MEM.
    always_ff @(posedge clock or negedge reseta) begin
        if (!reseta) begin
            cont <= '0;
        end else if (est == BUSCA) begin
            cont <= 4'(LAT_MEM - 1);
        end else if (est == ESPERA_MEM && cont != '0) begin
            cont <= cont - 4'd1;
        end
    end

    // An advance cycle is a plain EXECUTA or the pulse cycle of ESPERA_IO.
    always_comb begin
        avanca = 1'b0;
        case (est)
            EXECUTA:   avanca = !bus.inst_hlt && !bus.inst_in;
            ESPERA_IO: avanca = pulso;
            default:   avanca = 1'b0;
        endcase
    end

    always_comb begin
        prox = est;
        case (est)
            INICIO:       prox = BUSCA;
            BUSCA:        prox = ESPERA_MEM;
            ESPERA_MEM:   if (cont == '0) prox = EXECUTA;
            EXECUTA: begin
                if (bus.inst_hlt)      prox = PARADO;
                else if (bus.inst_in)  prox = ESPERA_IO;
                else                   prox = passo_a_passo ? ESPERA_PASSO : BUSCA;
            end
            ESPERA_IO:    if (pulso) prox = passo_a_passo ? ESPERA_PASSO : BUSCA;
            ESPERA_PASSO: if (pulso) prox = BUSCA;
            PARADO:       prox = PARADO;
            default:      prox = INICIO;
        endcase
    end

    assign alvo_sel = bus.desvio_req ? bus.desvio_alvo : '0;

    always_comb begin
        bus.pc_reseta        = 1'b0;
        bus.pc_halt          = 1'b1;
        bus.pc_jump          = 1'b0;
        bus.pc_endereco      = '0;
        bus.ir_carrega       = 1'b0;
        bus.escreve_habilita = 1'b0;
        parado               = 1'b0;
        if (est == INICIO) bus.pc_reseta = 1'b1;
        if (est == ESPERA_MEM && cont == '0) bus.ir_carrega = 1'b1;
        if (est == PARADO) parado = 1'b1;
        if (avanca) begin
            bus.pc_halt          = 1'b0;
            bus.escreve_habilita = 1'b1;
            bus.pc_jump          = bus.desvio_req;
            bus.pc_endereco      = alvo_sel;
        end
    end

    assign estado = est;

endmodule
